fm_write_scheduler: RTL and testbench

- Sequences all writes into the feature-map buffer for one tile job.
- Shares the single FM write port between two requesters:
  - the conv engine write-back stream, which has no backpressure and strict priority;
  - the DDR load stream, which uses a valid/ready handshake and fills the next tile.
- Generates a separate base-relative write address for each stream and signals job completion to the layer controller.
- Sits between the conv output stage / DDR read mover and the FM memory write pre-process stage.

---
 rtl/fm_write_scheduler.sv | 123 ++++++++++++
 tb/tb_fm_write_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_write_scheduler.sv
// Feature-map write-port scheduler: merges the conv write-back stream (strict priority,
// no backpressure) with the DDR load stream (valid/ready) for one tile job.
module fm_write_scheduler #(
  parameter int CONV_OUT_NUM = 18,
  parameter int DATA_WIDTH   = 8,
  parameter int FM_MEM_DEPTH = 13,
  parameter int DDR_WIDTH    = 256
) (
  input  logic                                 sys_clk,
  input  logic                                 rstn,
  input  logic                                 cfg_start,
  input  logic [FM_MEM_DEPTH-1:0]              cfg_conv_base,
  input  logic [FM_MEM_DEPTH:0]                cfg_conv_len,
  input  logic [FM_MEM_DEPTH-1:0]              cfg_ddr_base,
  input  logic [FM_MEM_DEPTH:0]                cfg_ddr_len,
  input  logic [CONV_OUT_NUM*DATA_WIDTH-1:0]   Conv_wr_data,
  input  logic                                 Conv_wr_valid,
  input  logic [DDR_WIDTH-1:0]                 DDR_wr_data,
  input  logic                                 DDR_wr_valid,
  output logic                                 DDR_wr_ready,
  output logic [CONV_OUT_NUM*DATA_WIDTH-1:0]   wr_data,
  output logic [FM_MEM_DEPTH-1:0]              wr_addr,
  output logic                                 wr_en,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err_overrun,
  output logic [1:0]                           dbg_state
);

  localparam int W  = CONV_OUT_NUM * DATA_WIDTH;
  localparam int LW = FM_MEM_DEPTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [FM_MEM_DEPTH-1:0] conv_ptr, ddr_ptr;
  logic [LW-1:0]           conv_rem, ddr_rem;
  logic                    in_run, start_acc, conv_pend, conv_acc, ddr_acc, conv_drop;
  logic                    unused_ddr_hi;

  // Handshake: a DDR beat transfers in a cycle where DDR_wr_valid and DDR_wr_ready are
  // both high. Ready is combinational and drops whenever a conv word is claiming the port.
  assign in_run       = (state == RUN);
  assign start_acc    = (state == IDLE) && cfg_start;
  assign conv_pend    = Conv_wr_valid && (conv_rem != '0);
  assign conv_acc     = conv_pend && in_run;
  assign DDR_wr_ready = in_run && (ddr_rem != '0) && !conv_pend;
  assign ddr_acc      = DDR_wr_valid && DDR_wr_ready;
  assign conv_drop    = Conv_wr_valid && !conv_acc;

  assign busy          = in_run;
  assign done          = (state == DONE);
  assign dbg_state     = state;
  assign unused_ddr_hi = ^DDR_wr_data[DDR_WIDTH-1:W];

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = RUN;
      RUN:     if ((conv_rem == '0) && (ddr_rem == '0)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      conv_ptr <= '0;
      conv_rem <= '0;
      ddr_ptr  <= '0;
      ddr_rem  <= '0;
    end else if (start_acc) begin
      conv_ptr <= cfg_conv_base;
      conv_rem <= cfg_conv_len;
      ddr_ptr  <= cfg_ddr_base;
      ddr_rem  <= cfg_ddr_len;
    end else begin
      if (conv_acc) begin
        conv_ptr <= conv_ptr + FM_MEM_DEPTH'(1);
        conv_rem <= conv_rem - LW'(1);
      end
      if (ddr_acc) begin
        ddr_ptr <= ddr_ptr + FM_MEM_DEPTH'(1);
        ddr_rem <= ddr_rem - LW'(1);
      end
    end
  end

  // Write stage: address/data hold their last value when no word is accepted.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      wr_en   <= 1'b0;
      wr_data <= '0;
      wr_addr <= '0;
    end else begin
      wr_en <= conv_acc || ddr_acc;
      if (conv_acc) begin
        wr_data <= Conv_wr_data;
        wr_addr <= conv_ptr;
      end else if (ddr_acc) begin
        wr_data <= DDR_wr_data[W-1:0];
        wr_addr <= ddr_ptr;
      end
    end
  end

  // A word dropped in the same cycle as an accepted start still flags the error.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn)          err_overrun <= 1'b0;
    else if (conv_drop) err_overrun <= 1'b1;
    else if (start_acc) err_overrun <= 1'b0;
  end

endmodule

// File: tb/tb_fm_write_scheduler.sv
// Directed bench for fm_write_scheduler: expected writes are queued per job and
// checked by a write monitor; control/status outputs are checked inline.
module tb_fm_write_scheduler;

  localparam int CONV_OUT_NUM = 18;
  localparam int DATA_WIDTH   = 8;
  localparam int AW           = 13;
  localparam int DW           = 256;
  localparam int W            = CONV_OUT_NUM * DATA_WIDTH;

  logic          sys_clk, rstn, cfg_start;
  logic [AW-1:0] cfg_conv_base, cfg_ddr_base;
  logic [AW:0]   cfg_conv_len, cfg_ddr_len;
  logic [W-1:0]  Conv_wr_data;
  logic          Conv_wr_valid;
  logic [DW-1:0] DDR_wr_data;
  logic          DDR_wr_valid, DDR_wr_ready;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en, busy, done, err_overrun;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic [AW+W-1:0] exp_q[$];

  fm_write_scheduler #(
    .CONV_OUT_NUM(CONV_OUT_NUM), .DATA_WIDTH(DATA_WIDTH),
    .FM_MEM_DEPTH(AW), .DDR_WIDTH(DW)
  ) dut (
    .sys_clk(sys_clk), .rstn(rstn), .cfg_start(cfg_start),
    .cfg_conv_base(cfg_conv_base), .cfg_conv_len(cfg_conv_len),
    .cfg_ddr_base(cfg_ddr_base), .cfg_ddr_len(cfg_ddr_len),
    .Conv_wr_data(Conv_wr_data), .Conv_wr_valid(Conv_wr_valid),
    .DDR_wr_data(DDR_wr_data), .DDR_wr_valid(DDR_wr_valid), .DDR_wr_ready(DDR_wr_ready),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .busy(busy), .done(done), .err_overrun(err_overrun), .dbg_state(dbg_state)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every observed write must match the head of the expected queue
  always @(negedge sys_clk) begin
    if (rstn && wr_en) begin
      logic [AW+W-1:0] e;
      n_writes++;
      check("wr_expected", 256'(exp_q.size() > 0), 256'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 256'(wr_addr), 256'(e[AW+W-1:W]));
        check("wr_data", 256'(wr_data), 256'(e[W-1:0]));
      end
    end
  end

  function automatic logic [AW+W-1:0] ent(input int a, input logic [W-1:0] d);
    return {AW'(a), d};
  endfunction

  // DDR beat with junk in the upper bits, which must never reach the FM word
  function automatic logic [DW-1:0] mk_beat(input logic [W-1:0] v);
    logic [DW-1:0] d;
    d = '0;
    d[DW-1:W] = (DW-W)'({4{$urandom()}});
    d[W-1:0]  = v;
    return d;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic start_job(input int cb, input int cl, input int db, input int dl);
    cfg_conv_base = AW'(cb);
    cfg_conv_len  = (AW+1)'(cl);
    cfg_ddr_base  = AW'(db);
    cfg_ddr_len   = (AW+1)'(dl);
    cfg_start     = 1'b1;
    tick();
    cfg_start     = 1'b0;
  endtask

  // counts ticks until done is seen, then checks it is a one-cycle pulse
  task automatic wait_done(input string tag, input int exp_ticks);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        tick();
        n++;
      end
    end
    check({tag, "_done_delay"}, 256'(n), 256'(exp_ticks));
    check({tag, "_busy_at_done"}, 256'(busy), 256'(0));
    tick();
    check({tag, "_done_pulse"}, 256'(done), 256'(0));
    check({tag, "_state_idle"}, 256'(dbg_state), 256'(0));
  endtask

  initial begin
    int w0;
    rstn = 1'b0; cfg_start = 1'b0;
    cfg_conv_base = '0; cfg_conv_len = '0; cfg_ddr_base = '0; cfg_ddr_len = '0;
    Conv_wr_data = '0; Conv_wr_valid = 1'b0; DDR_wr_data = '0; DDR_wr_valid = 1'b0;
    tick(); tick();
    check("rst_wr_en", 256'(wr_en), 256'(0));
    check("rst_wr_addr", 256'(wr_addr), 256'(0));
    check("rst_wr_data", 256'(wr_data), 256'(0));
    check("rst_ready", 256'(DDR_wr_ready), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_err", 256'(err_overrun), 256'(0));
    check("rst_state", 256'(dbg_state), 256'(0));
    rstn = 1'b1;
    tick();

    // DDR-only load, with an ignored second start mid-job
    start_job(0, 0, 'h100, 4);
    check("t1_busy", 256'(busy), 256'(1));
    check("t1_state_run", 256'(dbg_state), 256'(1));
    for (int i = 1; i <= 4; i++) begin
      DDR_wr_valid = 1'b1;
      DDR_wr_data  = mk_beat(W'(i));
      if (i == 2) begin
        cfg_start = 1'b1; cfg_ddr_base = AW'('h500); cfg_ddr_len = (AW+1)'(9);
      end
      #1;
      check("t1_ready", 256'(DDR_wr_ready), 256'(1));
      exp_q.push_back(ent('h100 + i - 1, W'(i)));
      tick();
      cfg_start = 1'b0;
      check("t1_wr_en", 256'(wr_en), 256'(1));
    end
    DDR_wr_valid = 1'b0;
    wait_done("t1", 1);

    // contention: conv words take the port first, DDR held off
    w0 = n_writes;
    start_job('h200, 3, 'h300, 3);
    for (int c = 0; c < 6; c++) begin
      Conv_wr_valid = (c < 3);
      Conv_wr_data  = W'('hC00 + c);
      DDR_wr_valid  = 1'b1;
      DDR_wr_data   = mk_beat(W'('hD00 + ((c < 3) ? 0 : c - 3)));
      #1;
      check("t2_ready", 256'(DDR_wr_ready), 256'(c >= 3));
      if (c < 3) exp_q.push_back(ent('h200 + c, W'('hC00 + c)));
      else       exp_q.push_back(ent('h300 + c - 3, W'('hD00 + c - 3)));
      tick();
    end
    Conv_wr_valid = 1'b0;
    DDR_wr_valid  = 1'b0;
    wait_done("t2", 1);
    check("t2_nwrites", 256'(n_writes - w0), 256'(6));

    // address wrap
    start_job(8190, 4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      Conv_wr_valid = 1'b1;
      Conv_wr_data  = W'('hE00 + i);
      exp_q.push_back(ent((8190 + i) % 8192, W'('hE00 + i)));
      tick();
    end
    Conv_wr_valid = 1'b0;
    wait_done("t3", 1);
    check("t3_err", 256'(err_overrun), 256'(0));

    // overrun: third conv word is dropped
    w0 = n_writes;
    start_job('h010, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      Conv_wr_valid = 1'b1;
      Conv_wr_data  = W'('hF00 + i);
      if (i < 2) exp_q.push_back(ent('h010 + i, W'('hF00 + i)));
      tick();
      check("t4_err", 256'(err_overrun), 256'(i == 2));
    end
    Conv_wr_valid = 1'b0;
    wait_done("t4", 0);
    check("t4_err_sticky", 256'(err_overrun), 256'(1));
    check("t4_nwrites", 256'(n_writes - w0), 256'(2));

    // zero-length job: start clears the error, no writes
    w0 = n_writes;
    start_job(0, 0, 0, 0);
    check("t5_err_cleared", 256'(err_overrun), 256'(0));
    check("t5_busy", 256'(busy), 256'(1));
    wait_done("t5", 1);
    Conv_wr_valid = 1'b1;
    Conv_wr_data  = W'('h999);
    tick();
    Conv_wr_valid = 1'b0;
    tick();
    check("t5_idle_drop_err", 256'(err_overrun), 256'(1));
    check("t5_nwrites", 256'(n_writes - w0), 256'(0));

    // asynchronous reset mid-job, then a fresh job
    start_job(0, 0, 'h040, 5);
    check("t6_err_cleared", 256'(err_overrun), 256'(0));
    for (int i = 1; i <= 2; i++) begin
      DDR_wr_valid = 1'b1;
      DDR_wr_data  = mk_beat(W'('h50 + i));
      if (i == 1) exp_q.push_back(ent('h040, W'('h51)));
      tick();
    end
    check("t6_pending_wr", 256'(wr_en), 256'(1));
    rstn = 1'b0;
    #1;
    check("t6_rst_wr_en", 256'(wr_en), 256'(0));
    check("t6_rst_wr_addr", 256'(wr_addr), 256'(0));
    check("t6_rst_wr_data", 256'(wr_data), 256'(0));
    check("t6_rst_ready", 256'(DDR_wr_ready), 256'(0));
    check("t6_rst_busy", 256'(busy), 256'(0));
    check("t6_rst_state", 256'(dbg_state), 256'(0));
    DDR_wr_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    start_job(0, 0, 'h040, 2);
    for (int i = 1; i <= 2; i++) begin
      DDR_wr_valid = 1'b1;
      DDR_wr_data  = mk_beat(W'('h60 + i));
      exp_q.push_back(ent('h040 + i - 1, W'('h60 + i)));
      tick();
    end
    DDR_wr_valid = 1'b0;
    wait_done("t6", 1);

    tick();
    check("exp_q_empty", 256'(exp_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
